// File: rtl/sync_fifo_v3_if.sv
// Bus-side bundle for sync_fifo_v3: push/pop handshake, data and status.
// The master drives requests; the FIFO sits on the slave modport.
interface sync_fifo_v3_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic             flush;
   logic             enq;
   logic             deq;
   logic             err_clr;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             empty;
   logic             full;
   logic [CW-1:0]    count;
   logic             almost_full;
   logic             almost_empty;
   logic             overflow;
   logic             underflow;

   modport master (
      output flush, enq, deq, err_clr, data_in,
      input  data_out, empty, full, count,
      input  almost_full, almost_empty,
      input  overflow, underflow
   );

   modport slave (
      input  flush, enq, deq, err_clr, data_in,
      output data_out, empty, full, count,
      output almost_full, almost_empty,
      output overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_v3.sv
// First-word-fall-through synchronous FIFO, all DEPTH entries usable.
// Define FIFO_ERR_EN to build the sticky overflow/underflow flags.
module sync_fifo_v3 #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned AFULL_LVL  = 12,
   parameter int unsigned AEMPTY_LVL = 2
) (
   input  logic           clk,
   input  logic           rst,
   sync_fifo_v3_if.slave  bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] AF_LVL = CW'(AFULL_LVL);
   localparam logic [CW-1:0] AE_LVL = CW'(AEMPTY_LVL);

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [CW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_w;

   logic empty_w;
   logic full_w;
   logic push;
   logic pop;

   // Wrap bit distinguishes full from empty when low bits match.
   assign empty_w = (wr_ptr_q == rd_ptr_q);
   assign full_w  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign count_w = wr_ptr_q - rd_ptr_q;

   assign push = bus.enq && !full_w && !bus.flush;
   assign pop  = bus.deq && !empty_w && !bus.flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (bus.flush) begin
         rd_ptr_d = wr_ptr_q;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is never cleared; stale words are hidden by the pointers.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= bus.data_in;
      end
   end

   assign bus.data_out     = mem_q[rd_ptr_q[AW-1:0]];
   assign bus.empty        = empty_w;
   assign bus.full         = full_w;
   assign bus.count        = count_w;
   assign bus.almost_full  = (count_w >= AF_LVL);
   assign bus.almost_empty = (count_w <= AE_LVL);

`ifdef FIFO_ERR_EN
   logic ovf_q, ovf_d;
   logic unf_q, unf_d;

   // A fresh error in the clear cycle must not be lost.
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (bus.err_clr) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      if (bus.enq && full_w)  ovf_d = 1'b1;
      if (bus.deq && empty_w) unf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
`else
   logic unused_err_clr;

   assign unused_err_clr = bus.err_clr;
   assign bus.overflow   = 1'b0;
   assign bus.underflow  = 1'b0;
`endif
endmodule

// File: tb/tb_sync_fifo_v3.sv
// Bench for sync_fifo_v3: vector table, directed corners, random vs queue model.
// Expected error-flag behaviour follows FIFO_ERR_EN as compiled.
module tb_sync_fifo_v3;
   localparam int W   = 32;
   localparam int D   = 16;
   localparam int AFL = 12;
   localparam int AEL = 2;
   localparam int CW  = $clog2(D) + 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   sync_fifo_v3_if #(.WIDTH(W), .DEPTH(D)) bus ();

   sync_fifo_v3 #(
      .WIDTH(W), .DEPTH(D),
      .AFULL_LVL(AFL), .AEMPTY_LVL(AEL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   logic [W-1:0] mq [$];
   bit m_ovf;
   bit m_unf;
   bit seen_ff;

   typedef struct {
      bit           r, e, d, f, c;
      logic [W-1:0] din;
      int           cnt;
      bit           emp;
      bit           ful;
      logic [W-1:0] dout;
   } vec_t;

   vec_t tbl [$];

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drv(bit r, bit e, bit d, bit f, bit c, logic [W-1:0] x);
      rst         = r;
      bus.enq     = e;
      bus.deq     = d;
      bus.flush   = f;
      bus.err_clr = c;
      bus.data_in = x;
   endtask

   // Reference: a queue of words plus two sticky bits.
   task automatic model_upd();
      bit fl;
      bit em;
      fl = (mq.size() == D);
      em = (mq.size() == 0);
      if (rst) begin
         mq.delete();
         m_ovf = 0;
         m_unf = 0;
      end else begin
`ifdef FIFO_ERR_EN
         if (bus.err_clr) begin
            m_ovf = 0;
            m_unf = 0;
         end
         if (bus.enq && fl) m_ovf = 1;
         if (bus.deq && em) m_unf = 1;
`endif
         if (bus.flush) begin
            mq.delete();
         end else begin
            if (bus.deq && !em) void'(mq.pop_front());
            if (bus.enq && !fl) mq.push_back(bus.data_in);
         end
      end
   endtask

   task automatic check_all();
      int n;
      n = mq.size();
      chk("count", 64'(bus.count), 64'(n));
      chk("empty", 64'(bus.empty), 64'(n == 0));
      chk("full", 64'(bus.full), 64'(n == D));
      chk("almost_full", 64'(bus.almost_full), 64'(n >= AFL));
      chk("almost_empty", 64'(bus.almost_empty), 64'(n <= AEL));
      chk("overflow", 64'(bus.overflow), 64'(m_ovf));
      chk("underflow", 64'(bus.underflow), 64'(m_unf));
      if (n != 0) chk("data_out", 64'(bus.data_out), 64'(mq[0]));
   endtask

   task automatic step();
      model_upd();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic add(bit r, bit e, bit d, bit f, bit c,
                      logic [W-1:0] x, int n, bit em, bit fu,
                      logic [W-1:0] o);
      vec_t v;
      v.r = r; v.e = e; v.d = d; v.f = f; v.c = c;
      v.din = x; v.cnt = n; v.emp = em; v.ful = fu; v.dout = o;
      tbl.push_back(v);
   endtask

   initial begin
      drv(1, 0, 0, 0, 0, '0);
      m_ovf = 0;
      m_unf = 0;

      // rst, 5 pushes, 5 pops, pop on empty, push+pop on empty, flush+enq
      add(1, 0, 0, 0, 0, 32'h0,  0, 1, 0, 32'h0);
      for (int i = 0; i < 5; i++)
         add(0, 1, 0, 0, 0, 32'hA0 + i, i + 1, 0, 0, 32'hA0);
      for (int i = 0; i < 4; i++)
         add(0, 0, 1, 0, 0, 32'h0, 4 - i, 0, 0, 32'hA1 + i);
      add(0, 0, 1, 0, 0, 32'h0,  0, 1, 0, 32'h0);
      add(0, 0, 1, 0, 0, 32'h0,  0, 1, 0, 32'h0);
      add(0, 1, 1, 0, 0, 32'hB0, 1, 0, 0, 32'hB0);
      add(0, 1, 0, 1, 0, 32'hB1, 0, 1, 0, 32'h0);

      foreach (tbl[k]) begin
         drv(tbl[k].r, tbl[k].e, tbl[k].d, tbl[k].f, tbl[k].c, tbl[k].din);
         step();
         chk("tbl_count", 64'(bus.count), 64'(tbl[k].cnt));
         chk("tbl_empty", 64'(bus.empty), 64'(tbl[k].emp));
         chk("tbl_full", 64'(bus.full), 64'(tbl[k].ful));
         if (!tbl[k].emp)
            chk("tbl_dout", 64'(bus.data_out), 64'(tbl[k].dout));
      end

      // Fill to 16, then a dropped push while full
      drv(1, 0, 0, 0, 0, '0);
      step();
      for (int i = 0; i < D; i++) begin
         drv(0, 1, 0, 0, 0, 32'h100 + i);
         step();
      end
      chk("fill_full", 64'(bus.full), 64'd1);
      chk("fill_count", 64'(bus.count), 64'd16);
      drv(0, 1, 0, 0, 0, 32'hFF);
      step();
      chk("drop_count", 64'(bus.count), 64'd16);
`ifdef FIFO_ERR_EN
      chk("ovf_set", 64'(bus.overflow), 64'd1);
`else
      chk("ovf_tied", 64'(bus.overflow), 64'd0);
`endif

      // Push+pop while full: pop only
      drv(0, 1, 1, 0, 0, 32'hEE);
      step();
      chk("fullpp_count", 64'(bus.count), 64'd15);
      chk("fullpp_full", 64'(bus.full), 64'd0);
      chk("fullpp_head", 64'(bus.data_out), 64'h101);
      seen_ff = 0;
      for (int i = 0; i < 15; i++) begin
         if (bus.data_out == 32'hFF || bus.data_out == 32'hEE) seen_ff = 1;
         drv(0, 0, 1, 0, 0, '0);
         step();
      end
      chk("no_dropped_word", 64'(seen_ff), 64'd0);

      // Watermarks up to 14, flush at 8 with enq asserted
      for (int i = 0; i < 14; i++) begin
         drv(0, 1, 0, 0, 0, 32'h200 + i);
         step();
         chk("af_edge", 64'(bus.almost_full), 64'(i + 1 >= AFL));
      end
      for (int i = 0; i < 6; i++) begin
         drv(0, 0, 1, 0, 0, '0);
         step();
      end
      chk("pre_flush_cnt", 64'(bus.count), 64'd8);
      drv(0, 1, 0, 1, 0, 32'h333);
      step();
      chk("flush_count", 64'(bus.count), 64'd0);
      chk("flush_empty", 64'(bus.empty), 64'd1);
      for (int i = 0; i < 4; i++) begin
         drv(0, 1, 0, 0, 0, 32'h300 + i);
         step();
         chk("ae_edge", 64'(bus.almost_empty), 64'(i + 1 <= AEL));
      end

      // Reset mid-stream with enq, then underflow and clear
      for (int i = 0; i < 3; i++) begin
         drv(0, 1, 0, 0, 0, 32'h400 + i);
         step();
      end
      chk("pre_rst_cnt", 64'(bus.count), 64'd7);
      drv(1, 1, 0, 0, 0, 32'h4FF);
      step();
      chk("rst_count", 64'(bus.count), 64'd0);
      chk("rst_ovf", 64'(bus.overflow), 64'd0);
      drv(0, 0, 1, 0, 0, '0);
      step();
`ifdef FIFO_ERR_EN
      chk("unf_set", 64'(bus.underflow), 64'd1);
`else
      chk("unf_tied", 64'(bus.underflow), 64'd0);
`endif
      drv(0, 0, 0, 0, 1, '0);
      step();
      chk("unf_clr", 64'(bus.underflow), 64'd0);

      // Random bursts alternating fill-heavy and drain-heavy
      for (int i = 0; i < 1200; i++) begin
         bit heavy;
         heavy = ((i / 40) % 2) == 0;
         drv(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 9) < (heavy ? 8 : 3)),
             ($urandom_range(0, 9) < (heavy ? 3 : 8)),
             ($urandom_range(0, 79) == 0),
             ($urandom_range(0, 39) == 0),
             $urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
